// File: rtl/led_rate_sequencer.sv
// led_rate_sequencer: steps the LED blinker through a latched list of 2-bit rate codes, each held DWELL_CNT cycles.
// Define LED_RATE_SEQ_GAP_EN to insert a GAP_CNT-cycle LED-off gap at every step boundary.
module led_rate_sequencer #(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned DWELL_CNT = 25000,
  parameter int unsigned GAP_CNT   = 2500,
  localparam int unsigned SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_repeat,
  input  logic [2*NUM_STEPS-1:0] i_pattern,
  output logic                   o_switch_1,
  output logic                   o_switch_2,
  output logic                   o_enable,
  output logic                   o_busy,
  output logic [SW-1:0]          o_step,
  output logic                   o_done
);
  localparam int unsigned DW = (DWELL_CNT > 1) ? $clog2(DWELL_CNT) : 1;
  localparam int unsigned GW = (GAP_CNT > 1) ? $clog2(GAP_CNT) : 1;
`ifdef LED_RATE_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t                     r_state, w_state;
  logic [NUM_STEPS-1:0][1:0]  r_pattern, w_pattern;
  logic [SW-1:0]              r_step, w_step, w_step_nxt;
  logic [DW-1:0]              r_dwell, w_dwell;
  logic [GW-1:0]              r_gap, w_gap;
  logic [1:0]                 r_sw, w_sw;
  logic                       r_enable, w_enable;
  logic                       r_busy, w_busy;
  logic                       r_done, w_done;
  logic                       w_last, w_dwell_end, w_gap_end;

  assign w_last      = r_step == SW'(NUM_STEPS - 1);
  assign w_dwell_end = r_dwell == DW'(DWELL_CNT - 1);
  assign w_gap_end   = r_gap == GW'(GAP_CNT - 1);
  assign w_step_nxt  = w_last ? '0 : r_step + 1'b1;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_step    <= '0;
      r_dwell   <= '0;
      r_gap     <= '0;
      r_sw      <= '0;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pattern <= w_pattern;
      r_step    <= w_step;
      r_dwell   <= w_dwell;
      r_gap     <= w_gap;
      r_sw      <= w_sw;
      r_enable  <= w_enable;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  // Next values of every output are computed here so all outputs leave a flop.
  always_comb begin
    w_state   = r_state;
    w_pattern = r_pattern;
    w_step    = r_step;
    w_dwell   = r_dwell;
    w_gap     = r_gap;
    w_sw      = r_sw;
    w_enable  = r_enable;
    w_busy    = r_busy;
    w_done    = 1'b0;
    if (i_stop) begin
      w_state  = IDLE;
      w_step   = '0;
      w_dwell  = '0;
      w_gap    = '0;
      w_sw     = '0;
      w_enable = 1'b0;
      w_busy   = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          w_state   = RUN;
          w_pattern = i_pattern;
          w_step    = '0;
          w_dwell   = '0;
          w_sw      = i_pattern[1:0];
          w_enable  = 1'b1;
          w_busy    = 1'b1;
        end
        RUN: begin
          w_dwell = w_dwell_end ? '0 : r_dwell + 1'b1;
          if (w_dwell_end) begin
            if (w_last && !i_repeat) begin
              w_state  = DONE;
              w_sw     = '0;
              w_enable = 1'b0;
              w_done   = 1'b1;
            end else if (GAP_EN) begin
              w_state  = GAP;
              w_gap    = '0;
              w_enable = 1'b0;
            end else begin
              w_step = w_step_nxt;
              w_sw   = r_pattern[w_step_nxt];
            end
          end
        end
        GAP: begin
          w_gap = w_gap_end ? '0 : r_gap + 1'b1;
          if (w_gap_end) begin
            w_state  = RUN;
            w_step   = w_step_nxt;
            w_sw     = r_pattern[w_step_nxt];
            w_enable = 1'b1;
          end
        end
        DONE: begin
          w_state  = IDLE;
          w_step   = '0;
          w_sw     = '0;
          w_enable = 1'b0;
          w_busy   = 1'b0;
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign o_switch_1 = r_sw[1];
  assign o_switch_2 = r_sw[0];
  assign o_enable   = r_enable;
  assign o_busy     = r_busy;
  assign o_step     = r_step;
  assign o_done     = r_done;
endmodule

// File: tb/tb_led_rate_sequencer.sv
// tb_led_rate_sequencer: directed table, corner sequences and random stimulus against a timeline model.
module tb_led_rate_sequencer;
  localparam int N  = 4;
  localparam int DW = 4;
`ifdef LED_RATE_SEQ_GAP_EN
  localparam int GP = 2;
`else
  localparam int GP = 0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       s = 1'b0, p = 1'b0, r = 1'b0;
  logic [7:0] pat = '0;
  logic       sw1, sw2, en, busy, done;
  logic [1:0] step;

  always #5 clk = ~clk;

  led_rate_sequencer #(.NUM_STEPS(N), .DWELL_CNT(DW), .GAP_CNT(2)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(s), .i_stop(p), .i_repeat(r),
    .i_pattern(pat), .o_switch_1(sw1), .o_switch_2(sw2), .o_enable(en),
    .o_busy(busy), .o_step(step), .o_done(done)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 active, 2 done; t counts cycles since the current step began,
  // with t >= DW meaning the LED-off gap that follows the step's dwell.
  int         m_phase = 0, m_t = 0, m_step = 0;
  logic [7:0] m_pat = '0;

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_step = 0; m_pat = '0;
  endtask

  task automatic model_edge();
    if (!rst_n || p) begin
      m_phase = 0; m_t = 0; m_step = 0;
    end else if (m_phase == 0) begin
      if (s) begin m_phase = 1; m_pat = pat; m_step = 0; m_t = 0; end
    end else if (m_phase == 2) begin
      m_phase = 0; m_step = 0;
    end else if (m_t == DW - 1) begin
      if (m_step == N - 1 && !r) m_phase = 2;
      else if (GP > 0) m_t = DW;
      else begin m_step = (m_step + 1) % N; m_t = 0; end
    end else if (m_t == DW + GP - 1) begin
      m_step = (m_step + 1) % N; m_t = 0;
    end else m_t++;
  endtask

  function automatic int exp_sw();
    return (m_phase == 1) ? int'(m_pat[2*m_step +: 2]) : 0;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_sw"}, int'({sw1, sw2}), exp_sw());
    chk({tag, "_en"}, int'(en), (m_phase == 1 && m_t < DW) ? 1 : 0);
    chk({tag, "_busy"}, int'(busy), (m_phase != 0) ? 1 : 0);
    chk({tag, "_done"}, int'(done), (m_phase == 2) ? 1 : 0);
    chk({tag, "_step"}, int'(step), (m_phase == 0) ? 0 : m_step);
  endtask

  task automatic tick(input logic ts, input logic tp, input logic tr, input logic [7:0] tpat);
    s = ts; p = tp; r = tr; pat = tpat;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic s, p, r;
    logic [7:0] pat;
    int sw, en, busy, done, step;
  } vec_t;

  function automatic vec_t mk(input logic vs, vp, vr, input logic [7:0] vpat,
                              input int vsw, ven, vbusy, vdone, vstep);
    vec_t v;
    v.s = vs; v.p = vp; v.r = vr; v.pat = vpat;
    v.sw = vsw; v.en = ven; v.busy = vbusy; v.done = vdone; v.step = vstep;
    return v;
  endfunction

  vec_t tbl[$];
  int   dones;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sw", int'({sw1, sw2}), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step", int'(step), 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 8'h00);
    check_model("idle");

    // One-shot with pattern 00_01_10_11; mid-run start and pattern change must be ignored.
    tbl.push_back(mk(1, 1, 0, 8'h1B, 0, 0, 0, 0, 0));
    for (int k = 0; k < N; k++) begin
      for (int d = 0; d < DW; d++)
        tbl.push_back(mk((k == 0 && d == 0) || (k == 1 && d == 2), 0, 0,
                         (k >= 1) ? 8'hFF : 8'h1B, 3 - k, 1, 1, 0, k));
      if (k < N - 1)
        for (int g = 0; g < GP; g++) tbl.push_back(mk(0, 0, 0, 8'hFF, 3 - k, 0, 1, 0, k));
    end
    tbl.push_back(mk(0, 0, 0, 8'h1B, 0, 0, 1, 1, N - 1));
    tbl.push_back(mk(0, 0, 0, 8'h1B, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      tick(tbl[i].s, tbl[i].p, tbl[i].r, tbl[i].pat);
      chk($sformatf("tbl%0d_sw", i), int'({sw1, sw2}), tbl[i].sw);
      chk($sformatf("tbl%0d_en", i), int'(en), tbl[i].en);
      chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), int'(done), tbl[i].done);
      chk($sformatf("tbl%0d_step", i), int'(step), tbl[i].step);
    end

    // Repeat for two passes, then drop i_repeat and expect exactly one done pulse.
    tick(1, 0, 1, 8'h1B);
    check_model("rpt");
    repeat (2 * N * (DW + GP)) begin
      tick(0, 0, 1, 8'h1B);
      check_model("rpt");
    end
    dones = 0;
    repeat (N * (DW + GP) + 4) begin
      tick(0, 0, 0, 8'h1B);
      check_model("rpt_end");
      if (done) dones++;
    end
    chk("rpt_done_pulses", dones, 1);

    // Stop during step 1.
    tick(1, 0, 0, 8'hE4);
    repeat (DW + GP) tick(0, 0, 0, 8'hE4);
    check_model("pre_stop");
    tick(0, 1, 0, 8'hE4);
    chk("stop_en", int'(en), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    tick(0, 0, 0, 8'hE4);
    chk("after_stop_done", int'(done), 0);
    check_model("after_stop");

    // Asynchronous reset in step 2.
    tick(1, 0, 0, 8'h1B);
    repeat (2 * (DW + GP)) tick(0, 0, 0, 8'h1B);
    check_model("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sw", int'({sw1, sw2}), 0);
    chk("arst_en", int'(en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_step", int'(step), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0, 8'h1B);
    chk("post_rst_busy", int'(busy), 0);
    check_model("post_rst");

    repeat (800) begin
      tick(($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0, 8'($urandom));
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
